// File: rtl/pattern_scan_sequencer.sv
// pattern_scan_sequencer: round-robin front end sharing one bit-serial
// 3-tap pattern detector between two word-oriented requesters.
module pattern_scan_sequencer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req0_valid,
    output logic                            req0_ready,
    input  logic [WIDTH-1:0]                req0_data,
    input  logic                            req1_valid,
    output logic                            req1_ready,
    input  logic [WIDTH-1:0]                req1_data,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic                            res_id,
    output logic [$clog2(WIDTH+1)-1:0]      res_cnt_hi,
    output logic [$clog2(WIDTH+1)-1:0]      res_cnt_lo,
    output logic                            det_step,
    output logic [1:0]                      det_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    logic [1:0]       state,      state_d;
    logic [WIDTH-1:0] word,       word_d;
    logic [CW-1:0]    step,       step_d;
    logic [2:0]       hist,       hist_d;
    logic             last_grant, last_grant_d;
    logic             res_id_d;
    logic             res_valid_d;
    logic             det_step_d;
    logic [CW-1:0]    cnt_hi_d,   cnt_lo_d;

    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic             bit_k;
    logic [1:0]       det_o_c;

    // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == IDLE) && grant_any;
    end

    assign req0_ready = (state == IDLE) && grant_any && !grant_id;
    assign req1_ready = (state == IDLE) && grant_any &&  grant_id;

    // Detector taps: hist[0]=b(k-1), hist[1]=b(k-2), hist[2]=b(k-3); the word shifts right each step.
    always_comb begin
        bit_k   = word[0];
        det_o_c = {bit_k & ~hist[1] & ~hist[2], bit_k & hist[1] & hist[2]};
    end

    assign det_o = det_step ? det_o_c : 2'b00;

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_d      = state;
        word_d       = word;
        step_d       = step;
        hist_d       = hist;
        last_grant_d = last_grant;
        res_id_d     = res_id;
        res_valid_d  = res_valid;
        det_step_d   = det_step;
        cnt_hi_d     = res_cnt_hi;
        cnt_lo_d     = res_cnt_lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    word_d       = grant_id ? req1_data : req0_data;
                    res_id_d     = grant_id;
                    last_grant_d = grant_id;
                    cnt_hi_d     = '0;
                    cnt_lo_d     = '0;
                    hist_d       = 3'b000;
                    step_d       = '0;
                    det_step_d   = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                word_d   = word >> 1;
                hist_d   = {hist[1:0], bit_k};
                cnt_hi_d = res_cnt_hi + CW'(det_o_c[1]);
                cnt_lo_d = res_cnt_lo + CW'(det_o_c[0]);
                step_d   = step + CW'(1);
                if (step == CW'(WIDTH - 1)) begin
                    det_step_d  = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                det_step_d  = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State register; reset aborts any job in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            step       <= '0;
            hist       <= 3'b000;
            last_grant <= 1'b1;
            res_id     <= 1'b0;
            res_valid  <= 1'b0;
            det_step   <= 1'b0;
            res_cnt_hi <= '0;
            res_cnt_lo <= '0;
        end else begin
            state      <= state_d;
            word       <= word_d;
            step       <= step_d;
            hist       <= hist_d;
            last_grant <= last_grant_d;
            res_id     <= res_id_d;
            res_valid  <= res_valid_d;
            det_step   <= det_step_d;
            res_cnt_hi <= cnt_hi_d;
            res_cnt_lo <= cnt_lo_d;
        end
    end

endmodule
